// File: rtl/idli_pkg.sv
// Shared types and helpers for the idli stack-vop sequencer.
package idli_pkg;

  typedef enum logic [1:0] {
    STK_IDLE = 2'd0,
    STK_ADJ  = 2'd1,
    STK_XFER = 2'd2
  } stk_state_t;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/idli_stk_ffs_m.sv
// Priority encoder: picks the lowest (desc=0) or highest (desc=1) set bit of vec.
module idli_stk_ffs_m #(
  parameter int NREGS = 8,
  parameter int IDX_W = 3
) (
  input  logic [NREGS-1:0] vec,
  input  logic             desc,
  output logic [IDX_W-1:0] idx,
  output logic [NREGS-1:0] onehot
);

  logic             found_s;
  logic [IDX_W-1:0] pos_s;

  // Scan in the preferred order; the first set bit encountered wins.
  always_comb begin
    found_s = 1'b0;
    pos_s   = '0;
    idx     = '0;
    for (int k = 0; k < NREGS; k++) begin
      pos_s = desc ? IDX_W'(NREGS - 1 - k) : IDX_W'(k);
      if (vec[pos_s] && !found_s) begin
        idx     = pos_s;
        found_s = 1'b1;
      end else begin
        idx     = idx;
      end
    end
    if (found_s) begin
      onehot = NREGS'(1) << idx;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/idli_stk_seq_m.sv
// PUSH/POP register-list sequencer: one SP-adjust slot, then one transfer slot per mask bit.
// Build option: IDLI_STK_DESC_ORDER_EN makes PUSH transfer highest register first.
module idli_stk_seq_m
  import idli_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int IDX_W = 3
) (
  input  logic             i_stk_gck,
  input  logic             i_stk_rst_n,
  input  logic [1:0]       i_stk_ctr,
  input  logic             i_stk_start,
  input  logic             i_stk_push,
  input  logic [NREGS-1:0] i_stk_mask,
  input  logic [1:0]       i_stk_pred,
  input  logic             i_stk_rdy,
  input  logic             i_stk_flush,
  output logic             o_stk_vld,
  output logic             o_stk_adj,
  output logic [IDX_W-1:0] o_stk_reg,
  output logic [3:0]       o_stk_cnt,
  output logic             o_stk_push,
  output logic [1:0]       o_stk_pred,
  output logic             o_stk_last,
  output logic             o_stk_busy
);

  stk_state_t       state_r;
  logic [NREGS-1:0] mask_r;
  logic             push_r;
  logic [1:0]       pred_r;
  logic [3:0]       cnt_r;

  logic             slot_end_s;
  logic             desc_s;
  logic [IDX_W-1:0] idx_s;
  logic [NREGS-1:0] onehot_s;
  logic             one_left_s;
  logic             busy_s;

  assign slot_end_s = (i_stk_ctr == 2'd3);
  assign one_left_s = ((mask_r & ~onehot_s) == '0);
  assign busy_s     = (state_r != STK_IDLE);

`ifdef IDLI_STK_DESC_ORDER_EN
  assign desc_s = push_r;
`else
  assign desc_s = 1'b0;
`endif

  idli_stk_ffs_m #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_ffs (
    .vec    (mask_r),
    .desc   (desc_s),
    .idx    (idx_s),
    .onehot (onehot_s)
  );

  // Sequencer state and captured vop fields; flush overrides any slot-boundary action.
  always_ff @(posedge i_stk_gck) begin
    if (!i_stk_rst_n) begin
      state_r <= STK_IDLE;
      mask_r  <= '0;
      push_r  <= 1'b0;
      pred_r  <= 2'd0;
      cnt_r   <= 4'd0;
    end else if (i_stk_flush) begin
      state_r <= STK_IDLE;
      mask_r  <= '0;
    end else if (slot_end_s) begin
      case (state_r)
        STK_IDLE: begin
          if (i_stk_start && (i_stk_mask != '0)) begin
            state_r <= STK_ADJ;
            mask_r  <= i_stk_mask;
            push_r  <= i_stk_push;
            pred_r  <= i_stk_pred;
            cnt_r   <= popcnt8(i_stk_mask);
          end
        end
        STK_ADJ: begin
          if (i_stk_rdy) begin
            state_r <= STK_XFER;
          end
        end
        STK_XFER: begin
          if (i_stk_rdy) begin
            mask_r <= mask_r & ~onehot_s;
            if (one_left_s) begin
              state_r <= STK_IDLE;
            end
          end
        end
        default: begin
          state_r <= STK_IDLE;
          mask_r  <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state; everything reads zero while idle.
  always_comb begin
    o_stk_vld  = busy_s;
    o_stk_busy = busy_s;
    o_stk_adj  = 1'b0;
    o_stk_reg  = '0;
    o_stk_last = 1'b0;
    o_stk_cnt  = 4'd0;
    o_stk_push = 1'b0;
    o_stk_pred = 2'd0;
    if (busy_s) begin
      o_stk_cnt  = cnt_r;
      o_stk_push = push_r;
      o_stk_pred = pred_r;
    end else begin
      o_stk_cnt  = 4'd0;
    end
    case (state_r)
      STK_ADJ:  o_stk_adj = 1'b1;
      STK_XFER: begin
        o_stk_reg  = idx_s;
        o_stk_last = one_left_s;
      end
      default:  o_stk_adj = 1'b0;
    endcase
  end

endmodule
